// File: rtl/matmul_pkg.sv
// Shared types and constants for the matmul stream controller.
package matmul_pkg;

  // Default configuration of the matmul core this controller serves.
  localparam int MM_N     = 2;
  localparam int MM_WIDTH = 8;
  localparam int NELEM    = MM_N * MM_N;
  localparam int FRAME    = 2 * NELEM;

  // Core pipeline depth: multiplier stages plus one adder stage set per tree level.
  localparam int MULT_LAT = 3;
  localparam int ADD_LAT  = 2;

  typedef logic signed [MM_WIDTH-1:0] elem_t;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  // Total core latency from operand change to valid result.
  function automatic int calc_mm_latency(input int mult_lat, input int add_lat, input int n);
    return mult_lat + add_lat * $clog2(n);
  endfunction

endpackage

// File: rtl/matmul_stream_ctrl.sv
// Stream front/back end for the N x N matmul core: packs A/B from an input
// stream, waits out the core latency, then serialises C to an output stream.
module matmul_stream_ctrl
  import matmul_pkg::*;
#(
  parameter int N          = MM_N,
  parameter int WIDTH      = MM_WIDTH,
  parameter int MM_LATENCY = calc_mm_latency(MULT_LAT, ADD_LAT, MM_N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [WIDTH-1:0]       s_data,
  input  logic                   s_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WIDTH-1:0]       m_data,
  output logic                   m_last,
  output logic [N*N*WIDTH-1:0]   mm_a_flat,
  output logic [N*N*WIDTH-1:0]   mm_b_flat,
  input  logic [N*N*WIDTH-1:0]   mm_c_flat,
  output logic                   busy,
  output logic                   frame_err
);

  localparam int NEL    = N * N;
  localparam int FRM    = 2 * N * N;
  localparam int IDX_W  = $clog2(FRM);
  localparam int OCNT_W = $clog2(NEL);
  localparam int WCNT_W = $clog2(MM_LATENCY + 1);

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(FRM - 1);
  localparam logic [OCNT_W-1:0] OCNT_LAST = OCNT_W'(NEL - 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MM_LATENCY);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [OCNT_W-1:0]   ocnt_q, ocnt_d;
  logic                frame_err_q, frame_err_d;
  logic [N*N*WIDTH-1:0] a_flat_q, b_flat_q, result_q;

  logic accept;
  logic capture;

  assign accept  = (state_q == S_LOAD) && s_valid;
  assign capture = (state_q == S_WAIT) && (wcnt_q == WCNT_LAST);

  // Next-state logic for the frame FSM, counters and sticky framing flag.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wcnt_d      = wcnt_q;
    ocnt_d      = ocnt_q;
    frame_err_d = frame_err_q;
    case (state_q)
      S_LOAD: begin
        if (s_valid) begin
          // idx alone defines framing; s_last is only cross-checked.
          if (s_last != (idx_q == IDX_LAST)) frame_err_d = 1'b1;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = S_WAIT;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_WAIT: begin
        if (wcnt_q == WCNT_LAST) begin
          wcnt_d  = '0;
          state_d = S_DRAIN;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (m_ready) begin
          if (ocnt_q == OCNT_LAST) begin
            ocnt_d  = '0;
            state_d = S_LOAD;
          end else begin
            ocnt_d = ocnt_q + OCNT_W'(1);
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_LOAD;
      idx_q       <= '0;
      wcnt_q      <= '0;
      ocnt_q      <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wcnt_q      <= wcnt_d;
      ocnt_q      <= ocnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Operand slots fill only in LOAD, so the core sees stable inputs afterwards;
  // the result is sampled once the core pipeline has flushed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_flat_q <= '0;
      b_flat_q <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        if (int'(idx_q) < NEL) a_flat_q[int'(idx_q)*WIDTH +: WIDTH] <= s_data;
        else                   b_flat_q[(int'(idx_q)-NEL)*WIDTH +: WIDTH] <= s_data;
      end
      if (capture) result_q <= mm_c_flat;
    end
  end

  assign s_ready   = (state_q == S_LOAD);
  assign m_valid   = (state_q == S_DRAIN);
  assign m_data    = m_valid ? result_q[int'(ocnt_q)*WIDTH +: WIDTH] : '0;
  assign m_last    = m_valid && (ocnt_q == OCNT_LAST);
  assign busy      = (state_q != S_LOAD);
  assign frame_err = frame_err_q;
  assign mm_a_flat = a_flat_q;
  assign mm_b_flat = b_flat_q;

endmodule

// File: tb/tb_matmul_stream_ctrl.sv
// Bench for matmul_stream_ctrl with a latency-5 behavioural matmul core.
module tb_matmul_stream_ctrl;
  import matmul_pkg::*;

  localparam int N  = 2;
  localparam int W  = 8;
  localparam int FW = N * N * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid, s_ready, s_last;
  logic [W-1:0]  s_data;
  logic          m_valid, m_ready, m_last;
  logic [W-1:0]  m_data;
  logic [FW-1:0] mm_a_flat, mm_b_flat, mm_c_flat;
  logic          busy, frame_err;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   rdy_mode = 0;
  logic [FW-1:0] cur_a = '0, cur_b = '0;
  logic [FW-1:0] pipe [0:4];
  logic          stall_prev = 1'b0, busy_prev = 1'b0;
  logic [W-1:0]  hold_data;
  logic          hold_last;

  matmul_stream_ctrl #(.N(N), .WIDTH(W), .MM_LATENCY(5)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .mm_a_flat(mm_a_flat), .mm_b_flat(mm_b_flat), .mm_c_flat(mm_c_flat),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] core_fn(input logic [FW-1:0] a, input logic [FW-1:0] b);
    logic [FW-1:0] c;
    int acc;
    c = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        acc = 0;
        for (int k = 0; k < N; k++)
          acc += int'($signed(a[(i*N+k)*W +: W])) * int'($signed(b[(k*N+j)*W +: W]));
        c[(i*N+j)*W +: W] = acc[W-1:0];
      end
    return c;
  endfunction

  // Behavioural core: five register stages from operands to result.
  initial for (int k = 0; k < 5; k++) pipe[k] = '0;
  always @(posedge clk) begin
    pipe[0] <= core_fn(mm_a_flat, mm_b_flat);
    for (int k = 1; k < 5; k++) pipe[k] <= pipe[k-1];
  end
  assign mm_c_flat = pipe[4];

  // Output sink: always ready, or ready one cycle in three.
  initial begin
    int cyc;
    cyc = 0;
    m_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      m_ready = (rdy_mode == 0) ? 1'b1 : (cyc % 3 == 0);
    end
  end

  // Monitor: scoreboard pops, stall stability, operand hold while busy.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
      busy_prev  = 1'b0;
    end else begin
      if (m_valid && stall_prev) begin
        chk("hold_data", m_data, hold_data);
        chk("hold_last", m_last, hold_last);
      end
      if (m_valid && !m_ready) begin
        chk("sready_stall", s_ready, 1'b0);
        stall_prev = 1'b1;
        hold_data  = m_data;
        hold_last  = m_last;
      end else begin
        stall_prev = 1'b0;
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("m_data", m_data, e.data);
          chk("m_last", m_last, e.last);
        end
      end
      if (busy && busy_prev) begin
        chk("a_hold", mm_a_flat, cur_a);
        chk("b_hold", mm_b_flat, cur_b);
      end
      busy_prev = busy;
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_s_ready"}, s_ready, 1'b1);
    chk({tag, "_m_valid"}, m_valid, 1'b0);
    chk({tag, "_m_last"}, m_last, 1'b0);
    chk({tag, "_m_data"}, m_data, '0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_frame_err"}, frame_err, 1'b0);
    chk({tag, "_a_flat"}, mm_a_flat, '0);
    chk({tag, "_b_flat"}, mm_b_flat, '0);
  endtask

  // Drive one frame; bad_idx >= 0 adds a spurious s_last on that element.
  task automatic send_frame(input logic [FW-1:0] a, input logic [FW-1:0] b,
                            input logic [FW-1:0] c_exp, input bit bubbles,
                            input int bad_idx, input bit push_exp);
    int k;
    for (int idx = 0; idx < 2*N*N; idx++) begin
      if (bubbles) begin
        k = 0;
        while ($urandom_range(1, 0) == 1 && k < 10) begin
          s_valid = 1'b0;
          @(posedge clk); #1;
          k++;
        end
      end
      s_valid = 1'b1;
      s_data  = (idx < N*N) ? a[idx*W +: W] : b[(idx-N*N)*W +: W];
      s_last  = (idx == 2*N*N-1) || (idx == bad_idx);
      @(posedge clk); #1;
      if (idx == bad_idx) chk("frame_err_set", frame_err, 1'b1);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    cur_a = a;
    cur_b = b;
    chk("a_packing", mm_a_flat, a);
    chk("b_packing", mm_b_flat, b);
    if (push_exp)
      for (int e = 0; e < N*N; e++) sb.push_back('{data: c_exp[e*W +: W], last: (e == N*N-1)});
  endtask

  task automatic wait_first_valid();
    int k;
    k = 0;
    while (!m_valid && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("first_valid_lat", k, 6);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!(sb.size() == 0 && s_ready && !m_valid) && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_done", sb.size(), 0);
    chk("idle_s_ready", s_ready, 1'b1);
  endtask

  logic [FW-1:0] a1, b1, c1, a2, b2, c2;

  initial begin
    a1 = {8'h04, 8'h03, 8'h02, 8'h01};
    b1 = {8'h01, 8'h00, 8'h00, 8'h01};
    c1 = {8'h04, 8'h03, 8'h02, 8'h01};
    a2 = {8'hFC, 8'h03, 8'h02, 8'hFF};
    b2 = {8'h08, 8'h07, 8'h06, 8'h05};
    c2 = {8'hF2, 8'hF3, 8'h0A, 8'h09};

    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst0");
    rst = 1'b0;
    @(posedge clk); #1;

    // Identity
    send_frame(a1, b1, c1, 1'b0, -1, 1'b1);
    wait_first_valid();
    wait_idle();
    chk("s1_frame_err", frame_err, 1'b0);

    // Signed
    send_frame(a2, b2, c2, 1'b0, -1, 1'b1);
    wait_first_valid();
    wait_idle();

    // Backpressure
    rdy_mode = 1;
    send_frame(a2, b2, c2, 1'b0, -1, 1'b1);
    wait_first_valid();
    wait_idle();
    rdy_mode = 0;

    // Input bubbles
    send_frame(a2, b2, c2, 1'b1, -1, 1'b1);
    wait_first_valid();
    wait_idle();
    chk("s4_frame_err", frame_err, 1'b0);

    // Framing error on idx 4
    send_frame(a2, b2, c2, 1'b0, 4, 1'b1);
    wait_first_valid();
    wait_idle();
    chk("frame_err_sticky", frame_err, 1'b1);

    // Reset during WAIT at wcnt == 2
    send_frame(a1, b1, c1, 1'b0, -1, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    cur_a = '0;
    cur_b = '0;
    check_reset_vals("rst_wait");
    @(posedge clk); #1;
    check_reset_vals("rst_hold");
    rst = 1'b0;
    @(posedge clk); #1;
    send_frame(a1, b1, c1, 1'b0, -1, 1'b1);
    wait_first_valid();
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
